// File: rtl/pong_pkg.sv
// Shared definitions for the pong engine: state encoding, default geometry
// and helpers that derive centre positions and far-edge limits.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3
    } state_t;

    localparam int DEF_H_RES            = 640;
    localparam int DEF_V_RES            = 480;
    localparam int DEF_WALL             = 10;
    localparam int DEF_PADDLE_LEN       = 50;
    localparam int DEF_PADDLE_THK       = 10;
    localparam int DEF_BALL_SIZE        = 10;
    localparam int DEF_P1_X             = 39;
    localparam int DEF_P2_X             = 590;
    localparam int DEF_PADDLE_STEP      = 8;
    localparam int DEF_V_MIN            = 2;
    localparam int DEF_V_MAX            = 6;
    localparam int DEF_HITS_PER_SPEEDUP = 4;
    localparam int DEF_WIN_SCORE        = 9;
    localparam int DEF_SERVE_DELAY      = 60;
    localparam int DEF_SCORE_W          = 4;

    // Top-left coordinate that centres an object of 'size' within 'extent'.
    function automatic logic [9:0] centre_pos(input int extent, input int size);
        return 10'((extent - size) / 2);
    endfunction

    // Largest top-left coordinate that keeps an object inside the far wall.
    function automatic int far_limit(input int extent, input int wall, input int size);
        return extent - wall - size;
    endfunction

    localparam logic [9:0] DEF_BALL_X0 = centre_pos(DEF_H_RES, DEF_BALL_SIZE);
    localparam logic [9:0] DEF_BALL_Y0 = centre_pos(DEF_V_RES, DEF_BALL_SIZE);
    localparam logic [9:0] DEF_PAD_Y0  = centre_pos(DEF_V_RES, DEF_PADDLE_LEN);

endpackage

// File: rtl/pong_paddle.sv
// One paddle's vertical position: steps on command, clamped between the walls,
// and snaps back to the centre when a point is scored.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int MIN_Y    = DEF_WALL,
    parameter int MAX_Y    = DEF_V_RES - DEF_WALL - DEF_PADDLE_LEN,
    parameter int STEP     = DEF_PADDLE_STEP,
    parameter int CENTRE_Y = 215
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move,
    input  logic       recentre,
    input  logic       up,
    input  logic       down,
    output logic [9:0] pos
);

    logic [9:0] pos_r;
    logic [9:0] pos_s;

    // Next position: recentre wins, conflicting or absent commands hold.
    always_comb begin
        pos_s = pos_r;
        if (recentre) begin
            pos_s = 10'(CENTRE_Y);
        end else if (move && up && !down) begin
            pos_s = (pos_r < 10'(MIN_Y + STEP)) ? 10'(MIN_Y) : pos_r - 10'(STEP);
        end else if (move && down && !up) begin
            pos_s = (pos_r > 10'(MAX_Y - STEP)) ? 10'(MAX_Y) : pos_r + 10'(STEP);
        end else begin
            pos_s = pos_r;
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_r <= 10'(CENTRE_Y);
        end else begin
            pos_r <= pos_s;
        end
    end

    assign pos = pos_r;

endmodule

// File: rtl/pong_engine.sv
// Pong game core: serve timing, ball motion against walls and paddles,
// scoring and speed-up, all advanced only on frame_tick.
module pong_engine
    import pong_pkg::*;
#(
    parameter int H_RES            = DEF_H_RES,
    parameter int V_RES            = DEF_V_RES,
    parameter int WALL             = DEF_WALL,
    parameter int PADDLE_LEN       = DEF_PADDLE_LEN,
    parameter int PADDLE_THK       = DEF_PADDLE_THK,
    parameter int BALL_SIZE        = DEF_BALL_SIZE,
    parameter int P1_X             = DEF_P1_X,
    parameter int P2_X             = DEF_P2_X,
    parameter int PADDLE_STEP      = DEF_PADDLE_STEP,
    parameter int V_MIN            = DEF_V_MIN,
    parameter int V_MAX            = DEF_V_MAX,
    parameter int HITS_PER_SPEEDUP = DEF_HITS_PER_SPEEDUP,
    parameter int WIN_SCORE        = DEF_WIN_SCORE,
    parameter int SERVE_DELAY      = DEF_SERVE_DELAY,
    parameter int SCORE_W          = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               up1,
    input  logic               down1,
    input  logic               up2,
    input  logic               down2,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [9:0]         paddle1_y,
    output logic [9:0]         paddle2_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         speed,
    output logic               point1,
    output logic               point2,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam logic [9:0] BALL_X0  = centre_pos(H_RES, BALL_SIZE);
    localparam logic [9:0] BALL_Y0  = centre_pos(V_RES, BALL_SIZE);
    localparam logic [9:0] PAD_Y0   = centre_pos(V_RES, PADDLE_LEN);
    localparam logic [9:0] WALL_POS = 10'(WALL);
    localparam logic [9:0] BOTTOM   = 10'(far_limit(V_RES, WALL, BALL_SIZE));
    localparam logic [9:0] RIGHT    = 10'(far_limit(H_RES, WALL, BALL_SIZE));
    localparam logic [9:0] P1_FACE  = 10'(P1_X + PADDLE_THK);
    localparam logic [9:0] P2_STOP  = 10'(P2_X - BALL_SIZE);
    localparam logic signed [10:0] S_WALL    = {1'b0, WALL_POS};
    localparam logic signed [10:0] S_BOTTOM  = {1'b0, BOTTOM};
    localparam logic signed [10:0] S_RIGHT   = {1'b0, RIGHT};
    localparam logic signed [10:0] S_P1_FACE = {1'b0, P1_FACE};
    localparam logic signed [10:0] S_P2_STOP = {1'b0, P2_STOP};
    localparam int SC_W = $clog2(SERVE_DELAY + 1);
    localparam int HC_W = (HITS_PER_SPEEDUP > 1) ? $clog2(HITS_PER_SPEEDUP) : 1;

    state_t             state_r, state_s;
    logic [9:0]         ball_x_r, ball_x_s, ball_y_r, ball_y_s;
    logic               dx_r, dx_s, dy_r, dy_s;
    logic [2:0]         speed_r, speed_s;
    logic [SCORE_W-1:0] score1_r, score1_s, score2_r, score2_s;
    logic [SC_W-1:0]    serve_cnt_r, serve_cnt_s;
    logic [HC_W-1:0]    hit_cnt_r, hit_cnt_s;
    logic               point1_r, point1_s, point2_r, point2_s;
    logic               game_over_r, game_over_s;
    logic               pad_move_s, pad_centre_s, win_s;
    logic [9:0]         pad1_y_s, pad2_y_s;
    logic signed [10:0] bx_s, by_s, spd_s, nx_s, ny_s;
    logic               overlap1_s, overlap2_s, hit1_s, hit2_s;

    // dx_r/dy_r: 1 means left/up. Collisions use pre-update paddle positions.
    assign spd_s      = {8'd0, speed_r};
    assign bx_s       = {1'b0, ball_x_r};
    assign by_s       = {1'b0, ball_y_r};
    assign nx_s       = dx_r ? bx_s - spd_s : bx_s + spd_s;
    assign ny_s       = dy_r ? by_s - spd_s : by_s + spd_s;
    assign overlap1_s = ({1'b0, ball_y_r} + 11'(BALL_SIZE) > {1'b0, pad1_y_s}) &&
                        ({1'b0, ball_y_r} < {1'b0, pad1_y_s} + 11'(PADDLE_LEN));
    assign overlap2_s = ({1'b0, ball_y_r} + 11'(BALL_SIZE) > {1'b0, pad2_y_s}) &&
                        ({1'b0, ball_y_r} < {1'b0, pad2_y_s} + 11'(PADDLE_LEN));
    assign hit1_s     = dx_r && (bx_s >= S_P1_FACE) && (nx_s <= S_P1_FACE) && overlap1_s;
    assign hit2_s     = !dx_r && (bx_s <= S_P2_STOP) && (nx_s >= S_P2_STOP) && overlap2_s;

    // Next-state logic: game flow, ball resolution, scoring and speed-up.
    always_comb begin
        state_s      = state_r;
        ball_x_s     = ball_x_r;
        ball_y_s     = ball_y_r;
        dx_s         = dx_r;
        dy_s         = dy_r;
        speed_s      = speed_r;
        score1_s     = score1_r;
        score2_s     = score2_r;
        serve_cnt_s  = serve_cnt_r;
        hit_cnt_s    = hit_cnt_r;
        point1_s     = 1'b0;
        point2_s     = 1'b0;
        pad_move_s   = 1'b0;
        pad_centre_s = 1'b0;
        win_s        = 1'b0;
        if (frame_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_s = ST_SERVE;
                    else       state_s = ST_IDLE;
                end
                ST_SERVE: begin
                    if (!pause) begin
                        pad_move_s = 1'b1;
                        if (serve_cnt_r == SC_W'(SERVE_DELAY - 1)) begin
                            serve_cnt_s = '0;
                            state_s     = ST_PLAY;
                        end else begin
                            serve_cnt_s = serve_cnt_r + SC_W'(1);
                        end
                    end else begin
                        pad_move_s = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (!pause) begin
                        pad_move_s = 1'b1;
                        if (ny_s <= S_WALL) begin
                            ball_y_s = WALL_POS;
                            dy_s     = 1'b0;
                        end else if (ny_s >= S_BOTTOM) begin
                            ball_y_s = BOTTOM;
                            dy_s     = 1'b1;
                        end else begin
                            ball_y_s = ny_s[9:0];
                        end
                        if (hit1_s || hit2_s) begin
                            ball_x_s = hit1_s ? P1_FACE : P2_STOP;
                            dx_s     = hit2_s;
                            if (hit_cnt_r == HC_W'(HITS_PER_SPEEDUP - 1)) begin
                                hit_cnt_s = '0;
                                if (speed_r < 3'(V_MAX)) speed_s = speed_r + 3'd1;
                                else                     speed_s = speed_r;
                            end else begin
                                hit_cnt_s = hit_cnt_r + HC_W'(1);
                            end
                        end else if ((nx_s <= S_WALL) || (nx_s >= S_RIGHT)) begin
                            // Serve goes toward the player who just lost the point.
                            pad_centre_s = 1'b1;
                            ball_x_s     = BALL_X0;
                            ball_y_s     = BALL_Y0;
                            speed_s      = 3'(V_MIN);
                            hit_cnt_s    = '0;
                            dy_s         = ~dy_r;
                            if (nx_s <= S_WALL) begin
                                score2_s = score2_r + SCORE_W'(1);
                                point2_s = 1'b1;
                                dx_s     = 1'b1;
                                win_s    = (score2_r == SCORE_W'(WIN_SCORE - 1));
                            end else begin
                                score1_s = score1_r + SCORE_W'(1);
                                point1_s = 1'b1;
                                dx_s     = 1'b0;
                                win_s    = (score1_r == SCORE_W'(WIN_SCORE - 1));
                            end
                            state_s = win_s ? ST_OVER : ST_SERVE;
                        end else begin
                            ball_x_s = nx_s[9:0];
                        end
                    end else begin
                        pad_move_s = 1'b0;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_s  = ST_IDLE;
                        score1_s = '0;
                        score2_s = '0;
                    end else begin
                        state_s = ST_OVER;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign game_over_s = (state_s == ST_OVER);

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ball_x_r    <= BALL_X0;
            ball_y_r    <= BALL_Y0;
            dx_r        <= 1'b0;
            dy_r        <= 1'b0;
            speed_r     <= 3'(V_MIN);
            score1_r    <= '0;
            score2_r    <= '0;
            serve_cnt_r <= '0;
            hit_cnt_r   <= '0;
            point1_r    <= 1'b0;
            point2_r    <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ball_x_r    <= ball_x_s;
            ball_y_r    <= ball_y_s;
            dx_r        <= dx_s;
            dy_r        <= dy_s;
            speed_r     <= speed_s;
            score1_r    <= score1_s;
            score2_r    <= score2_s;
            serve_cnt_r <= serve_cnt_s;
            hit_cnt_r   <= hit_cnt_s;
            point1_r    <= point1_s;
            point2_r    <= point2_s;
            game_over_r <= game_over_s;
        end
    end

    pong_paddle #(
        .MIN_Y(WALL), .MAX_Y(far_limit(V_RES, WALL, PADDLE_LEN)),
        .STEP(PADDLE_STEP), .CENTRE_Y(int'(PAD_Y0))
    ) u_paddle1 (
        .clk(clk), .rst(rst), .move(pad_move_s), .recentre(pad_centre_s),
        .up(up1), .down(down1), .pos(pad1_y_s)
    );

    pong_paddle #(
        .MIN_Y(WALL), .MAX_Y(far_limit(V_RES, WALL, PADDLE_LEN)),
        .STEP(PADDLE_STEP), .CENTRE_Y(int'(PAD_Y0))
    ) u_paddle2 (
        .clk(clk), .rst(rst), .move(pad_move_s), .recentre(pad_centre_s),
        .up(up2), .down(down2), .pos(pad2_y_s)
    );

    assign ball_x    = ball_x_r;
    assign ball_y    = ball_y_r;
    assign paddle1_y = pad1_y_s;
    assign paddle2_y = pad2_y_s;
    assign score1    = score1_r;
    assign score2    = score2_r;
    assign speed     = speed_r;
    assign point1    = point1_r;
    assign point2    = point2_r;
    assign game_over = game_over_r;
    assign state     = state_r;

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
Parametrised successor to the single-speed game state machine. Owns ball and paddle positions, scoring, serve timing and progressive ball speed. Motion advances only on a one-cycle frame_tick, so update rate is independent of clk. Outputs feed the VGA renderer and the score/7-segment display blocks.

Parameters:
H_RES, 640, screen width in pixels
V_RES, 480, screen height in pixels
WALL, 10, border thickness on all four sides
PADDLE_LEN, 50, paddle height
PADDLE_THK, 10, paddle width
BALL_SIZE, 10, ball side length
P1_X, 39, left edge of paddle 1
P2_X, 590, left edge of paddle 2 (hit face)
PADDLE_STEP, 8, paddle pixels per tick
V_MIN, 2, serve speed in pixels per tick per axis
V_MAX, 6, speed ceiling
HITS_PER_SPEEDUP, 4, paddle hits per +1 speed
WIN_SCORE, 9, points to win
SERVE_DELAY, 60, ticks the ball is held at centre before a serve
SCORE_W, 4, score counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
frame_tick  in  1  one-cycle pulse per frame
start  in  1  level; leaves IDLE, restarts from OVER
pause  in  1  level; freezes all state in PLAY
up1, down1, up2, down2  in  1 each  paddle commands
ball_x, ball_y  out  10  ball top-left corner
paddle1_y, paddle2_y  out  10  paddle top edges
score1, score2  out  SCORE_W  player scores
speed  out  3  current ball speed
point1, point2  out  1  one-cycle pulse when that player scores
game_over  out  1  high in OVER
state  out  3  IDLE=0, SERVE=1, PLAY=2, OVER=3

Behaviour:
- Reset: ball (315,235) = ((H_RES-BALL_SIZE)/2, (V_RES-BALL_SIZE)/2); paddles 215; scores 0; speed V_MIN; dx=right, dy=down; hit and serve counters 0; pulses 0; state IDLE.
- All outputs are registered; an update on tick N appears on the cycle after tick N. No update occurs without frame_tick.
- IDLE: positions held at centre. start -> SERVE.
- SERVE: ball held at centre. Paddles move on each tick. After SERVE_DELAY ticks -> PLAY.
- PLAY, per tick, unless pause: paddles update, then the ball is resolved against the pre-update paddle positions.
- Paddles: exactly one of up/down moves by PADDLE_STEP, clamped to [WALL, V_RES-WALL-PADDLE_LEN]. Both or neither asserted: no move.
- Ball arithmetic is 11-bit signed. nx = x±speed, ny = y±speed.
- Vertical: if ny<=WALL, y=WALL and dy=down. If ny+BALL_SIZE>=V_RES-WALL, y=V_RES-WALL-BALL_SIZE and dy=up.
- Left hit: dx=left, x>=P1_X+PADDLE_THK, nx<=P1_X+PADDLE_THK, and vertical overlap (ball_y+BALL_SIZE>pad_y and ball_y<pad_y+PADDLE_LEN). Result: x=P1_X+PADDLE_THK, dx=right.
- Right hit is symmetric at face P2_X. Result: x=P2_X-BALL_SIZE, dx=left.
- Hit has priority over miss on the same tick.
- Each hit increments the hit counter. When it reaches HITS_PER_SPEEDUP, it clears and speed increments, saturating at V_MAX.
- Miss: with no hit, nx<=WALL scores for player 2; nx+BALL_SIZE>=H_RES-WALL scores for player 1.
- On a miss: increment score, pulse pointN, recentre ball and paddles, speed=V_MIN, clear hit counter, dx toward the player who lost the point, toggle dy.
- After a miss: -> OVER if the new score equals WIN_SCORE, else -> SERVE.
- OVER: everything frozen, game_over=1. start -> IDLE with scores cleared.
- pause in SERVE also stalls the serve counter. pause in IDLE/OVER has no effect.
- Asynchronous reset at any time returns all state to reset values immediately.

Decomposition:
- Shared package pong_pkg holds the state encoding, the centre-position constants derived from the parameters, and the playfield limit expressions.
- One sub-module, pong_paddle: one paddle's clamped up/down register. Instantiated twice.

Test Plan:
- Assert rst mid-PLAY -> next cycle outputs ball (315,235), paddles 215, scores 0, speed 2, state IDLE.
- Hold up1 for 30 ticks from 215 -> 207, 199, …, 15, then 10, and paddle1_y stays 10. up1 and down1 together -> no change.
- start, 60 ticks -> state PLAY. On PLAY tick 113, ball_y clamps to 460 and dy flips up.
- Paddle2 held at top (10): on PLAY tick 153 -> point1 pulses one cycle, score1=1, ball recentred, state SERVE, serve direction toward player 2.
- Move paddle2 to 400 before PLAY tick 133, HITS_PER_SPEEDUP=1 -> on tick 133 ball_x=580, dx=left, speed=3. Repeated hits saturate speed at 6.
- WIN_SCORE=2, two player-1 misses -> score2=2, game_over=1, frame_tick and inputs ignored. start -> IDLE with scores 0.
